axis_pkt_gen: RTL and testbench

- AXI-stream frame transmitter (traffic source); drives an axis_full_if master port.
- Generates a programmable number of frames of programmable beat length, with incrementing or LFSR payload and a configurable idle gap between frames.
- Fully honours downstream backpressure.
- Used to feed axis_fifo and other stream sinks in block- and system-level benches, and as on-chip built-in self-test stimulus.

---
 rtl/axis_pkt_gen_if.sv | 19 +
 rtl/axis_pkt_gen.sv | 134 +++++++++++++
 tb/tb_axis_pkt_gen.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkt_gen_if.sv
// axis_full_if: AXI-stream bus with tdata/tkeep/tlast/tid/tdest/tuser and valid/ready handshake
interface axis_full_if #(
  parameter int DATA_W = 8,
  parameter int KEEP_W = (DATA_W + 7) / 8,
  parameter int ID_W   = 8,
  parameter int DST_W  = 8,
  parameter int USR_W  = 1
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [DST_W-1:0]  tdest;
  logic [USR_W-1:0]  tuser;
  logic              tvalid;
  logic              tready;
  modport out (output tdata, tkeep, tlast, tid, tdest, tuser, tvalid, input tready);
  modport in  (input tdata, tkeep, tlast, tid, tdest, tuser, tvalid, output tready);
endinterface

// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI-stream frame generator with incrementing/LFSR payload, gaps and backpressure.
// Defining AXIS_PKT_GEN_ERR_INJ_EN adds err_inj, which flags one frame's last beat via tuser[0] and tdata[0].
module axis_pkt_gen #(
  parameter int DATA_W = 8,
  parameter int KEEP_W = (DATA_W + 7) / 8,
  parameter int ID_W   = 8,
  parameter int DST_W  = 8,
  parameter int USR_W  = 1,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              srst,
  axis_full_if.out          m_axis,
`ifdef AXIS_PKT_GEN_ERR_INJ_EN
  input  logic              err_inj,
`endif
  input  logic              start,
  input  logic              stop,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [LEN_W-1:0]  cfg_num_frames,
  input  logic [7:0]        cfg_gap,
  input  logic              cfg_mode,
  input  logic [DATA_W-1:0] cfg_seed,
  input  logic [ID_W-1:0]   cfg_id,
  input  logic [DST_W-1:0]  cfg_dest,
  output logic              busy,
  output logic              done,
  output logic [31:0]       stat_frames,
  output logic [31:0]       stat_beats
);
  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;
  state_t r_state, w_next;
  logic [LEN_W-1:0] r_len, r_nframes, r_beat, r_fcnt;
  logic [7:0] r_gap, r_gap_cnt;
  logic r_mode, r_stop;
  logic [DATA_W-1:0] r_seed;
  logic [ID_W-1:0] r_id;
  logic [DST_W-1:0] r_dest;
  logic [31:0] r_pay, r_stat_frames, r_stat_beats, w_load, w_adv;
  logic w_hs, w_last, w_eof, w_stop, w_run_end, w_err;
  assign w_load = (r_mode && r_seed == '0) ? 32'd1 : 32'(r_seed);
  // Fibonacci LFSR, taps 32,22,2,1 -> bits 31,21,1,0
  assign w_adv = r_mode ? {r_pay[30:0], r_pay[31] ^ r_pay[21] ^ r_pay[1] ^ r_pay[0]} : r_pay + 32'd1;
  assign w_last = r_beat == r_len - LEN_W'(1);
  assign w_hs = r_state == SEND && m_axis.tready;
  assign w_eof = w_hs && w_last;
  assign w_stop = r_stop || stop;
  assign w_run_end = w_stop || (r_nframes != '0 && r_fcnt + LEN_W'(1) == r_nframes);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? SEND : IDLE;
      SEND:    w_next = !w_eof ? SEND : w_run_end ? FIN : r_gap != 8'd0 ? GAP : SEND;
      GAP:     w_next = r_gap_cnt != 8'd1 ? GAP : w_stop ? FIN : SEND;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) r_state <= srst ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (srst) begin
      r_len <= '0;
      r_nframes <= '0;
      r_beat <= '0;
      r_fcnt <= '0;
      r_gap <= '0;
      r_gap_cnt <= '0;
      r_mode <= 1'b0;
      r_stop <= 1'b0;
      r_seed <= '0;
      r_id <= '0;
      r_dest <= '0;
      r_pay <= '0;
      r_stat_frames <= '0;
      r_stat_beats <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_len <= cfg_len == '0 ? LEN_W'(1) : cfg_len;
        r_nframes <= cfg_num_frames;
        r_gap <= cfg_gap;
        r_mode <= cfg_mode;
        r_seed <= cfg_seed;
        r_id <= cfg_id;
        r_dest <= cfg_dest;
        r_pay <= (cfg_mode && cfg_seed == '0) ? 32'd1 : 32'(cfg_seed);
        r_beat <= '0;
        r_fcnt <= '0;
        r_stop <= 1'b0;
        r_stat_frames <= '0;
        r_stat_beats <= '0;
      end
      if (r_state != IDLE && stop) r_stop <= 1'b1;
      if (r_state == GAP) r_gap_cnt <= r_gap_cnt - 8'd1;
      if (w_hs) begin
        r_stat_beats <= r_stat_beats + 32'd1;
        r_beat <= w_last ? '0 : r_beat + LEN_W'(1);
        r_pay <= w_last ? w_load : w_adv;
      end
      if (w_eof) begin
        r_stat_frames <= r_stat_frames + 32'd1;
        r_fcnt <= r_fcnt + LEN_W'(1);
        r_gap_cnt <= r_gap;
      end
    end
  end
`ifdef AXIS_PKT_GEN_ERR_INJ_EN
  // r_use is frozen while a last beat is stalled so its payload never changes mid-handshake
  logic r_arm, r_use, w_hold, w_use_hs;
  assign w_hold = r_state == SEND && w_last && !m_axis.tready;
  assign w_use_hs = w_eof && r_use;
  always_ff @(posedge clk) begin
    if (srst) begin
      r_arm <= 1'b0;
      r_use <= 1'b0;
    end else begin
      r_arm <= err_inj || (r_arm && !w_use_hs);
      r_use <= w_hold ? r_use : (err_inj || (r_arm && !w_use_hs));
    end
  end
  assign w_err = r_use && r_state == SEND && w_last;
`else
  assign w_err = 1'b0;
`endif
  assign m_axis.tvalid = r_state == SEND;
  assign m_axis.tlast = r_state == SEND && w_last;
  assign m_axis.tdata = r_pay[DATA_W-1:0] ^ DATA_W'(w_err);
  assign m_axis.tkeep = {KEEP_W{1'b1}};
  assign m_axis.tid = r_id;
  assign m_axis.tdest = r_dest;
  assign m_axis.tuser = USR_W'(w_err);
  assign busy = r_state == SEND || r_state == GAP;
  assign done = r_state == FIN;
  assign stat_frames = r_stat_frames;
  assign stat_beats = r_stat_beats;
endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb_axis_pkt_gen: directed bench for axis_pkt_gen with hand-computed expectations.
module tb_axis_pkt_gen;
  logic clk = 1'b0, srst = 1'b1, start = 1'b0, stop = 1'b0, tready = 1'b1, tgl = 1'b0;
  logic [15:0] cfg_len = '0, cfg_num_frames = '0;
  logic [7:0] cfg_gap = '0, cfg_seed = '0, cfg_id = '0, cfg_dest = '0;
  logic cfg_mode = 1'b0;
  logic busy, done;
  logic [31:0] stat_frames, stat_beats;
  int n_chk = 0, n_pass = 0, cyc = 0, done_cnt = 0, done_cyc = 0, s_cyc = 0;
  int idle_busy = 0, stall_cnt = 0, stab_err = 0, busy_drop = 0;
  logic [7:0] q_data[$];
  logic q_last[$];
  int q_cyc[$];
  logic p_stall = 1'b0, p_last = 1'b0;
  logic [7:0] p_data = '0;
  logic [7:0] lfsr_exp [6] = '{8'h01, 8'h03, 8'h06, 8'h01, 8'h03, 8'h06};
  axis_full_if #(.DATA_W(8), .KEEP_W(1), .ID_W(8), .DST_W(8), .USR_W(1)) ax ();
  assign ax.tready = tready;
  axis_pkt_gen dut (
    .clk(clk), .srst(srst), .m_axis(ax), .start(start), .stop(stop),
    .cfg_len(cfg_len), .cfg_num_frames(cfg_num_frames), .cfg_gap(cfg_gap),
    .cfg_mode(cfg_mode), .cfg_seed(cfg_seed), .cfg_id(cfg_id), .cfg_dest(cfg_dest),
    .busy(busy), .done(done), .stat_frames(stat_frames), .stat_beats(stat_beats)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (p_stall && (ax.tvalid !== 1'b1 || ax.tdata !== p_data || ax.tlast !== p_last)) stab_err++;
    p_stall = !srst && ax.tvalid && !tready;
    if (p_stall) stall_cnt++;
    p_data = ax.tdata;
    p_last = ax.tlast;
    if (!srst && ax.tvalid && tready) begin
      q_data.push_back(ax.tdata);
      q_last.push_back(ax.tlast);
      q_cyc.push_back(cyc);
    end
    if (!srst && busy && !ax.tvalid) idle_busy++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (tgl) tready = ~tready;
  endtask
  task automatic clr();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    idle_busy = 0;
    stall_cnt = 0;
    busy_drop = 0;
  endtask
  task automatic launch(input int len, input int frames, input int gap, input logic mode, input logic [7:0] seed);
    cfg_len = 16'(len);
    cfg_num_frames = 16'(frames);
    cfg_gap = 8'(gap);
    cfg_mode = mode;
    cfg_seed = seed;
    start = 1'b1;
    s_cyc = cyc;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 400 && done_cnt == d0; i++) begin
      tick();
      if (!busy && !done && done_cnt == d0 && q_data.size() > 0) busy_drop++;
    end
    tick();
    tick();
    chk({tag, "_done_once"}, done_cnt - d0, 1);
  endtask
  task automatic wait_q(input string tag, input int n);
    for (int i = 0; i < 400 && q_data.size() < n; i++) tick();
    chk({tag, "_beats_reached"}, q_data.size() >= n, 1);
  endtask
  task automatic chk_inc(input string tag, input int n, input logic [7:0] seed, input int len);
    chk({tag, "_nbeats"}, q_data.size(), n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), i < q_data.size() ? q_data[i] : 8'hxx, 8'(seed + 8'(i % len)));
      chk($sformatf("%s_last%0d", tag, i), i < q_last.size() ? q_last[i] : 1'bx, (i % len) == len - 1);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst_tvalid", ax.tvalid, 0);
    chk("rst_tlast", ax.tlast, 0);
    chk("rst_tdata", ax.tdata, 0);
    chk("rst_tuser", ax.tuser, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stat_frames", stat_frames, 0);
    chk("rst_stat_beats", stat_beats, 0);
    srst = 1'b0;
    tick();
    // run 1: 2 frames of 4, back-to-back; cfg changes and a second start mid-run are ignored
    clr();
    cfg_id = 8'h5A;
    cfg_dest = 8'hC3;
    launch(4, 2, 0, 1'b0, 8'h10);
    chk("t1_busy", busy, 1);
    chk("t1_tid", ax.tid, 8'h5A);
    chk("t1_tdest", ax.tdest, 8'hC3);
    chk("t1_tkeep", ax.tkeep, 1);
    chk("t1_tuser", ax.tuser, 0);
    cfg_seed = 8'h77;
    cfg_len = 16'd9;
    cfg_num_frames = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t1");
    chk_inc("t1", 8, 8'h10, 4);
    chk("t1_first_latency", q_cyc[0] - s_cyc, 2);
    chk("t1_contiguous", q_cyc[7] - q_cyc[0], 7);
    chk("t1_done_latency", done_cyc - q_cyc[7], 1);
    chk("t1_no_idle", idle_busy, 0);
    chk("t1_stat_frames", stat_frames, 2);
    chk("t1_stat_beats", stat_beats, 8);
    chk("t1_busy_end", busy, 0);
    // run 2: same config under alternating backpressure
    clr();
    tgl = 1'b1;
    launch(4, 2, 0, 1'b0, 8'h10);
    wait_done("t2");
    tgl = 1'b0;
    tready = 1'b1;
    chk_inc("t2", 8, 8'h10, 4);
    chk("t2_stalled", stall_cnt > 0, 1);
    chk("t2_stable", stab_err, 0);
    chk("t2_stat_beats", stat_beats, 8);
    // stop in IDLE is ignored; run 3 has gaps and wrapping payload
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("idle_stop_busy", busy, 0);
    clr();
    launch(2, 3, 5, 1'b0, 8'hFF);
    wait_done("t3");
    chk_inc("t3", 6, 8'hFF, 2);
    chk("t3_gap_cycles", idle_busy, 10);
    chk("t3_gap1", q_cyc[2] - q_cyc[1], 6);
    chk("t3_span", q_cyc[5] - q_cyc[0], 15);
    chk("t3_busy_held", busy_drop, 0);
    chk("t3_stat_frames", stat_frames, 3);
    // run 4: LFSR with seed 0, start and stop in the same cycle
    clr();
    stop = 1'b1;
    launch(3, 2, 0, 1'b1, 8'h00);
    stop = 1'b0;
    wait_done("t4");
    chk("t4_nbeats", q_data.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t4_data%0d", i), i < q_data.size() ? q_data[i] : 8'hxx, lfsr_exp[i]);
      chk($sformatf("t4_last%0d", i), i < q_last.size() ? q_last[i] : 1'bx, (i % 3) == 2);
    end
    chk("t4_stat_frames", stat_frames, 2);
    // run 5: continuous, stop during beat 2 of frame 3
    clr();
    launch(6, 0, 0, 1'b0, 8'h20);
    wait_q("t5", 14);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("t5");
    chk_inc("t5", 18, 8'h20, 6);
    chk("t5_stat_frames", stat_frames, 3);
    chk("t5_stat_beats", stat_beats, 18);
    // run 6: reset mid-frame under backpressure, then a len=0 run
    clr();
    launch(4, 2, 0, 1'b0, 8'h40);
    wait_q("t6", 2);
    tready = 1'b0;
    tick();
    tick();
    chk("t6_held_valid", ax.tvalid, 1);
    chk("t6_held_data", ax.tdata, 8'h42);
    chk("t6_pre_beats", stat_beats, 2);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk("t6_rst_tvalid", ax.tvalid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_beats", stat_beats, 0);
    chk("t6_rst_frames", stat_frames, 0);
    chk("t6_rst_tdata", ax.tdata, 0);
    tready = 1'b1;
    tick();
    clr();
    launch(0, 2, 0, 1'b0, 8'h55);
    wait_done("t6b");
    chk_inc("t6b", 2, 8'h55, 1);
    chk("t6b_stat_frames", stat_frames, 2);
    chk("t6b_stat_beats", stat_beats, 2);
    chk("all_stable", stab_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
